// File: rtl/aes_gcm_pkg.sv
// Shared definitions for the GCM counter-mode engine.
//   RND_SIZE / IV_SIZE / CTR_SIZE / KEEP_W : block, IV, counter and byte-enable widths
//   J0_CTR   : counter value that forms the pre-counter block J0 = {IV, 32'h1}
//   state_e  : engine FSM states
//   inc32()  : GCM counter increment; only the low CTR_SIZE bits move, modulo 2^32
//   keep_mask(): expands MSB-first byte enables into a bit mask over the block
package aes_gcm_pkg;

  localparam int RND_SIZE = 128;
  localparam int IV_SIZE  = 96;
  localparam int CTR_SIZE = RND_SIZE - IV_SIZE;
  localparam int KEEP_W   = RND_SIZE / 8;

  localparam logic [CTR_SIZE-1:0] J0_CTR = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_J0_REQ,
    ST_J0_WAIT,
    ST_KS_REQ,
    ST_KS_WAIT,
    ST_STREAM,
    ST_DRAIN
  } state_e;

  function automatic logic [CTR_SIZE-1:0] inc32(input logic [CTR_SIZE-1:0] c);
    return c + {{(CTR_SIZE-1){1'b0}}, 1'b1};
  endfunction

  // keep[KEEP_W-1] enables byte 0, which sits in the MSBs of the block.
  function automatic logic [RND_SIZE-1:0] keep_mask(input logic [KEEP_W-1:0] keep);
    logic [RND_SIZE-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_W; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

endpackage

// File: rtl/aes_core_top.sv
// Iterative AES-128 encryption core, one round per clock.
//   clk, rst_n : clock and synchronous active-low reset
//   i_en       : start an encryption; honoured only while o_ready=1
//   i_key      : cipher key, i_data : plaintext block (byte 0 = MSBs)
//   o_cypher   : ciphertext, valid in the cycle o_valid pulses
//   o_ready    : core idle and able to take i_en
// The S-box is computed as the GF(2^8) inverse (x^254) followed by the affine map,
// and the key schedule is expanded on the fly alongside the rounds.
module aes_core_top #(
  parameter int NUM_RND = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [127:0] i_key,
  input  logic [127:0] i_data,
  output logic [127:0] o_cypher,
  output logic         o_valid,
  output logic         o_ready
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x240, inv;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    inv  = gmul(gmul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Column-major state: byte index 4*col+row; the final round skips MixColumns.
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

  logic [127:0] state, rkey, nkey, nstate;
  logic [7:0]   rcon;
  logic [3:0]   rnd;
  logic         busy;

  assign nkey    = next_key(rkey, rcon);
  assign nstate  = enc_round(state, nkey, rnd == 4'(NUM_RND));
  assign o_ready = ~busy;

  // Round iteration: whitening on accept, then one round per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      o_valid <= 1'b0;
      rnd     <= '0;
    end else begin
      o_valid <= 1'b0;
      if (!busy) begin
        if (i_en) begin
          state <= i_data ^ i_key;
          rkey  <= i_key;
          rcon  <= 8'h01;
          rnd   <= 4'd1;
          busy  <= 1'b1;
        end
      end else begin
        state <= nstate;
        rkey  <= nkey;
        rcon  <= xtime(rcon);
        rnd   <= rnd + 4'd1;
        if (rnd == 4'(NUM_RND)) begin
          busy     <= 1'b0;
          o_valid  <= 1'b1;
          o_cypher <= nstate;
        end
      end
    end
  end

endmodule

// File: rtl/aes_gcm_ctr_engine.sv
// GCM counter-mode datapath around aes_core_top.
//   clk, rst           : clock, synchronous active-high reset
//   i_start/i_key/i_iv : start a message; key and 96-bit IV latched when idle
//   o_ekj0/o_ekj0_vld  : E(K,J0) for the tag, with a one-cycle update pulse
//   s_*                : input block stream (valid/ready, data, MSB-first keep, last)
//   m_*                : output block stream, s_data ^ keystream with disabled bytes zeroed
//   o_busy             : message in flight, from accepted start until last beat leaves
//   o_ctr_wrap         : sticky flag, counter wrapped 2^32-1 -> 0 during this message
// One keystream block is prefetched while the previous block waits in the stream,
// so AES rounds overlap with upstream/downstream stalls.
module aes_gcm_ctr_engine
  import aes_gcm_pkg::*;
#(
  parameter int NUM_RND = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [RND_SIZE-1:0] i_key,
  input  logic [IV_SIZE-1:0]  i_iv,
  output logic [RND_SIZE-1:0] o_ekj0,
  output logic                o_ekj0_vld,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [RND_SIZE-1:0] s_data,
  input  logic [KEEP_W-1:0]   s_keep,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [RND_SIZE-1:0] m_data,
  output logic [KEEP_W-1:0]   m_keep,
  output logic                m_last,
  output logic                o_busy,
  output logic                o_ctr_wrap
);

  state_e              state;
  logic [RND_SIZE-1:0] key_q, ks_buf, core_din, core_cypher;
  logic [IV_SIZE-1:0]  iv_q;
  logic [CTR_SIZE-1:0] ctr;
  logic                ks_full, core_en, core_valid, core_ready, s_fire;

  aes_core_top #(.NUM_RND(NUM_RND)) u_core (
    .clk      (clk),
    .rst_n    (~rst),
    .i_en     (core_en),
    .i_key    (key_q),
    .i_data   (core_din),
    .o_cypher (core_cypher),
    .o_valid  (core_valid),
    .o_ready  (core_ready)
  );

  // A block is taken only with keystream on hand and room in the output register,
  // counting a beat that retires in the same cycle as room.
  assign s_ready = (state == ST_STREAM) & ks_full & (~m_valid | m_ready);
  assign s_fire  = s_valid & s_ready;

  // Control: message sequencing, core requests, counter and keystream buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ks_full    <= 1'b0;
      core_en    <= 1'b0;
      o_busy     <= 1'b0;
      o_ctr_wrap <= 1'b0;
      o_ekj0     <= '0;
      o_ekj0_vld <= 1'b0;
    end else begin
      core_en    <= 1'b0;
      o_ekj0_vld <= 1'b0;
      unique case (state)
        ST_IDLE: if (i_start) begin
          key_q      <= i_key;
          iv_q       <= i_iv;
          o_ctr_wrap <= 1'b0;
          o_busy     <= 1'b1;
          state      <= ST_J0_REQ;
        end
        ST_J0_REQ: if (core_ready) begin
          core_en  <= 1'b1;
          core_din <= {iv_q, J0_CTR};
          state    <= ST_J0_WAIT;
        end
        ST_J0_WAIT: if (core_valid) begin
          o_ekj0     <= core_cypher;
          o_ekj0_vld <= 1'b1;
          ctr        <= inc32(J0_CTR);
          state      <= ST_KS_REQ;
        end
        ST_KS_REQ: if (core_ready) begin
          core_en  <= 1'b1;
          core_din <= {iv_q, ctr};
          state    <= ST_KS_WAIT;
        end
        ST_KS_WAIT: if (core_valid) begin
          ks_buf  <= core_cypher;
          ks_full <= 1'b1;
          ctr     <= inc32(ctr);
          if (&ctr) o_ctr_wrap <= 1'b1;
          state   <= ST_STREAM;
        end
        ST_STREAM: if (s_fire) begin
          ks_full <= 1'b0;
          state   <= s_last ? ST_DRAIN : ST_KS_REQ;
        end
        ST_DRAIN: if (m_valid && m_ready) begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: holds while stalled, reloads on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (s_fire) begin
      m_valid <= 1'b1;
      m_data  <= (s_data ^ ks_buf) & keep_mask(s_keep);
      m_keep  <= s_keep;
      m_last  <= s_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_gcm_ctr_engine.sv
// Scoreboard bench for aes_gcm_ctr_engine using NIST GCM vectors.
module tb_aes_gcm_ctr_engine;
  import aes_gcm_pkg::*;

  logic                clk = 1'b0;
  logic                rst, i_start, o_ekj0_vld, s_valid, s_ready, s_last;
  logic                m_valid, m_ready, m_last, o_busy, o_ctr_wrap;
  logic [RND_SIZE-1:0] i_key, o_ekj0, s_data, m_data;
  logic [IV_SIZE-1:0]  i_iv;
  logic [KEEP_W-1:0]   s_keep, m_keep;

  aes_gcm_ctr_engine dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_key(i_key), .i_iv(i_iv),
    .o_ekj0(o_ekj0), .o_ekj0_vld(o_ekj0_vld),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .o_busy(o_busy), .o_ctr_wrap(o_ctr_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [127:0] care;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  logic [127:0] ekj_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         rdy_toggle = 1'b0;

  localparam logic [127:0] ONES     = {128{1'b1}};
  localparam logic [127:0] EKJ0_K0  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C_K0     = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] H_K0     = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] TC3_KEY  = 128'hfeffe9928665731c6d6a8f9467308308;
  localparam logic [95:0]  TC3_IV   = 96'hcafebabefacedbaddecaf888;
  localparam logic [127:0] TC3_EKJ0 = 128'h3247184b3c4f69a44dbcd22887bbb418;

  logic [127:0] tc3_p [4] = '{128'hd9313225f88406e5a55909c5aff5269a,
                              128'h86a7a9531534f7da2e4c303d8a318a72,
                              128'h1c3c0c95956809532fcf0e2449a6b525,
                              128'hb16aedf5aa0de657ba637b391aafd255};
  logic [127:0] tc3_c [4] = '{128'h42831ec2217774244b7221b784d0d49c,
                              128'he3aa212f2c02a4e035c17e2329aca12e,
                              128'h21d514b25466931c7d8f6a5aac84aa05,
                              128'h1ba30b396a0aac973d58e091473f5985};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic push_beat(input logic [127:0] d, input logic [127:0] care,
                           input logic [15:0] k, input logic l);
    beat_t b;
    b.data = d; b.care = care; b.keep = k; b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic start_msg(input logic [127:0] k, input logic [95:0] iv);
    i_key = k; i_iv = iv; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d, input logic [15:0] k, input logic l);
    int n;
    n = 0;
    s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 1000);
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL s_ready_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, n);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy && n < 1000);
    chk({name, "_busy_fall"}, {127'd0, o_busy}, 128'd0);
    chk({name, "_beats_left"}, 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  // m_ready pattern: steady high, or alternating 1-0-1 each cycle
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rdy_toggle ? ~m_ready : 1'b1;
    end
  end

  // Monitor: compares each handshaken beat and each E(K,J0) pulse against the queues
  initial begin
    beat_t        e;
    logic [127:0] k;
    logic         prev_stall;
    logic [127:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (!m_valid || m_data !== prev_data) begin
          errors++;
          $display("FAIL hold: got valid=%b data=%h, expected valid=1 data=%h", m_valid, m_data, prev_data);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got data=%h, expected no beat", m_data);
        end else begin
          e = exp_q.pop_front();
          if (((m_data & e.care) !== (e.data & e.care)) || m_keep !== e.keep || m_last !== e.last) begin
            errors++;
            $display("FAIL beat: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b (care %h)",
                     m_data, m_keep, m_last, e.data, e.keep, e.last, e.care);
          end
        end
      end
      if (o_ekj0_vld) begin
        checks++;
        if (ekj_q.size() == 0) begin
          errors++;
          $display("FAIL ekj0_unexpected: got pulse with %h, expected none", o_ekj0);
        end else begin
          k = ekj_q.pop_front();
          if (o_ekj0 !== k) begin
            errors++;
            $display("FAIL ekj0: got %h, expected %h", o_ekj0, k);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; i_start = 1'b0; i_key = '0; i_iv = '0;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  {127'd0, o_busy},     128'd0);
    chk("rst_mvld",  {127'd0, m_valid},    128'd0);
    chk("rst_sready",{127'd0, s_ready},    128'd0);
    chk("rst_ekj0",  o_ekj0,               128'd0);
    chk("rst_wrap",  {127'd0, o_ctr_wrap}, 128'd0);
    chk("rst_mdata", m_data,               128'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // K=0, IV=0: E(K,J0) and a single zero block
    ekj_q.push_back(EKJ0_K0);
    start_msg('0, '0);
    push_beat(C_K0, ONES, 16'hFFFF, 1'b1);
    send_block('0, 16'hFFFF, 1'b1);
    wait_idle("tc2");

    // TC3, four blocks, downstream toggling, stray i_start while busy
    ekj_q.push_back(TC3_EKJ0);
    start_msg(TC3_KEY, TC3_IV);
    rdy_toggle = 1'b1;
    i_key = 128'h0123456789abcdef0123456789abcdef; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(tc3_c[i], ONES, 16'hFFFF, i == 3);
    for (int i = 0; i < 4; i++) send_block(tc3_p[i], 16'hFFFF, i == 3);
    wait_idle("tc3");
    rdy_toggle = 1'b0;

    // Partial final block: low four bytes disabled
    ekj_q.push_back(TC3_EKJ0);
    start_msg(TC3_KEY, TC3_IV);
    push_beat(128'h42831ec2217774244b7221b700000000, ONES, 16'hFFF0, 1'b1);
    send_block(tc3_p[0], 16'hFFF0, 1'b1);
    wait_idle("partial");

    // Counter wrap: the prefetch after block 1 uses ctr 2^32-1, block 3 uses ctr 0
    ekj_q.push_back(EKJ0_K0);
    start_msg('0, '0);
    n = 0;
    while (!s_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_stream_ready", {127'd0, s_ready}, 128'd1);
    force dut.ctr = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.ctr;
    chk("wrap_before", {127'd0, o_ctr_wrap}, 128'd0);
    push_beat(C_K0, ONES, 16'hFFFF, 1'b0);
    push_beat('0, '0, 16'hFFFF, 1'b0);
    push_beat(H_K0, ONES, 16'hFFFF, 1'b1);
    send_block('0, 16'hFFFF, 1'b0);
    send_block('0, 16'hFFFF, 1'b0);
    send_block('0, 16'hFFFF, 1'b1);
    wait_idle("wrap");
    chk("wrap_after", {127'd0, o_ctr_wrap}, 128'd1);

    // Reset during the first keystream fetch, then TC2 again
    ekj_q.push_back(TC3_EKJ0);
    start_msg(TC3_KEY, TC3_IV);
    chk("wrap_cleared", {127'd0, o_ctr_wrap}, 128'd0);
    n = 0;
    while (ekj_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_ekj0_seen", 128'(ekj_q.size()), 128'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",  {127'd0, o_busy},     128'd0);
    chk("abort_ekj0",  o_ekj0,               128'd0);
    chk("abort_mvld",  {127'd0, m_valid},    128'd0);
    chk("abort_ready", {127'd0, s_ready},    128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    ekj_q.push_back(EKJ0_K0);
    start_msg('0, '0);
    push_beat(C_K0, ONES, 16'hFFFF, 1'b1);
    send_block('0, 16'hFFFF, 1'b1);
    wait_idle("after_rst");
    chk("ekj0_hold", o_ekj0, EKJ0_K0);
    chk("ekj0_left", 128'(ekj_q.size()), 128'd0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
